// File: rtl/alu_tb_config_pkg.sv
// Shared ALU definitions: operand width, ALUOp encoding and a behavioural ALU
// function used to model the external ALU.
package alu_tb_config_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int SHAMT_W    = $clog2(DATA_WIDTH);

  typedef enum logic [7:0] {
    ADD   = 8'h00,
    SUB   = 8'h01,
    AND   = 8'h02,
    OR    = 8'h03,
    XOR   = 8'h04,
    SLL   = 8'h05,
    SRL   = 8'h06,
    SRA   = 8'h07,
    SLT   = 8'h08,
    SLTU  = 8'h09,
    PASSB = 8'h0A
  } alu_op_e;

  // Highest legal opcode; anything above it is rejected with an error response.
  localparam alu_op_e ALUOP_MAX = PASSB;

  function automatic logic [DATA_WIDTH-1:0] alu_ref(input logic [7:0]            op,
                                                    input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    case (op)
      ADD:     r = a + b;
      SUB:     r = a - b;
      AND:     r = a & b;
      OR:      r = a | b;
      XOR:     r = a ^ b;
      SLL:     r = a << b[SHAMT_W-1:0];
      SRL:     r = a >> b[SHAMT_W-1:0];
      SRA:     r = DATA_WIDTH'($signed(a) >>> b[SHAMT_W-1:0]);
      SLT:     r = DATA_WIDTH'($signed(a) < $signed(b));
      SLTU:    r = DATA_WIDTH'(a < b);
      PASSB:   r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last+1, wrapping,
// and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!any && req[(int'(last) + i) % N]) begin
        any                            = 1'b1;
        grant[(int'(last) + i) % N]    = 1'b1;
        grant_idx                      = IW'((int'(last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with round-robin
// arbitration and a single registered response channel.
module alu_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = alu_tb_config_pkg::DATA_WIDTH,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][7:0]             req_op,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b,
  output logic [7:0]                          alu_op,
  output logic [DATA_WIDTH-1:0]               alu_a,
  output logic [DATA_WIDTH-1:0]               alu_b,
  input  logic [DATA_WIDTH-1:0]               alu_result,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [ID_W-1:0]                     rsp_id,
  output logic [DATA_WIDTH-1:0]               rsp_result,
  output logic                                rsp_err
);

  import alu_tb_config_pkg::*;

  logic [ID_W-1:0]       last_q;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               can_issue;
  logic               xfer;
  logic               illegal;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // A response being popped this cycle frees the slot for a same-cycle grant.
  assign can_issue = !rsp_valid_q || rsp_ready;
  assign req_ready = (can_issue && !rst) ? grant : '0;
  assign xfer      = |req_ready;

  always_comb begin
    alu_op = ADD;
    alu_a  = req_a[0];
    alu_b  = req_b[0];
    if (grant_any) begin
      alu_op = req_op[grant_idx];
      alu_a  = req_a[grant_idx];
      alu_b  = req_b[grant_idx];
    end
  end

  assign illegal = alu_op > ALUOP_MAX;

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    if (xfer) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_idx;
      rsp_result_d = illegal ? '0 : alu_result;
      rsp_err_d    = illegal;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= ID_W'(NUM_REQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (xfer) last_q <= grant_idx;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a round-robin reference model predicts
// grants and responses; a negedge monitor checks the response channel.
module tb_alu_arbiter;
  import alu_tb_config_pkg::*;

  localparam int N  = 4;
  localparam int DW = DATA_WIDTH;
  localparam int IW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][7:0]    req_op;
  logic [N-1:0][DW-1:0] req_a;
  logic [N-1:0][DW-1:0] req_b;
  logic [7:0]           alu_op;
  logic [DW-1:0]        alu_a, alu_b, alu_result;
  logic                 rsp_valid, rsp_ready;
  logic [IW-1:0]        rsp_id;
  logic [DW-1:0]        rsp_result;
  logic                 rsp_err;

  alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // External ALU: combinational from the DUT's operand outputs.
  assign alu_result = alu_ref(alu_op, alu_a, alu_b);

  typedef struct {
    int            id;
    logic [DW-1:0] res;
    logic          err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_last;
  bit   m_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_last  = N - 1;
    m_valid = 1'b0;
    exp_q.delete();
  endfunction

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        check("rsp_id",     64'(rsp_id),     64'(exp_q[0].id));
        check("rsp_result", 64'(rsp_result), 64'(exp_q[0].res));
        check("rsp_err",    64'(rsp_err),    64'(exp_q[0].err));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One clock cycle: inputs are already driven; predict, compare, advance.
  task automatic tick(output int g, output logic [N-1:0] rdy);
    bit   can;
    rsp_t e;
    @(negedge clk);
    rdy = req_ready;
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    can = !m_valid || rsp_ready;
    g   = can ? model_grant(req_valid) : -1;
    check("req_ready", 64'(req_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
    if (g >= 0) begin
      e.id  = g;
      e.err = req_op[g] > 8'(ALUOP_MAX);
      e.res = e.err ? '0 : alu_ref(req_op[g], req_a[g], req_b[g]);
      exp_q.push_back(e);
      m_last  = g;
      m_valid = 1'b1;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input int id, input logic [DW-1:0] res,
                            input logic err);
    check({name, "_valid"},  64'(rsp_valid),  64'(1));
    check({name, "_id"},     64'(rsp_id),     64'(id));
    check({name, "_result"}, 64'(rsp_result), 64'(res));
    check({name, "_err"},    64'(rsp_err),    64'(err));
  endtask

  task automatic issue1(input int idx, input logic [7:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
    int           g;
    logic [N-1:0] rdy;
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    req_op[idx]    = op;
    req_a[idx]     = a;
    req_b[idx]     = b;
    rsp_ready      = 1'b1;
    tick(g, rdy);
    check("issue1_grant", 64'(rdy), 64'(1) << idx);
    req_valid = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           g;
    logic [N-1:0] rdy;
    logic [N-1:0] pend;

    rst       = 1'b1;
    req_valid = '1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready",  64'(req_ready),  64'(0));
    check("reset_rsp_valid",  64'(rsp_valid),  64'(0));
    check("reset_rsp_id",     64'(rsp_id),     64'(0));
    check("reset_rsp_result", 64'(rsp_result), 64'(0));
    check("reset_rsp_err",    64'(rsp_err),    64'(0));
    req_valid = '0;
    rst       = 1'b0;

    // Single request, one-cycle latency.
    issue1(0, ADD, 32'd5, 32'd7);
    expect_now("single", 0, 32'd12, 1'b0);
    tick(g, rdy);

    // Contention from a fresh pointer: strict rotation 0,1,2,3,0,1.
    apply_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < N; i++) begin
        req_op[i] = ADD;
        req_a[i]  = DW'(i * 16);
        req_b[i]  = DW'(j);
      end
      tick(g, rdy);
      check("rr_order", 64'(rdy), 64'(1) << (j % N));
    end
    req_valid = '0;
    tick(g, rdy);

    // Backpressure: response held three cycles, then same-cycle re-grant.
    issue1(2, XOR, 32'hA5A5_0000, 32'h0000_5A5A);
    rsp_ready = 1'b0;
    req_valid = 4'b1011;
    req_op[0] = SUB;  req_a[0] = 32'd9;  req_b[0] = 32'd4;
    req_op[1] = AND;  req_a[1] = 32'hFF; req_b[1] = 32'h0F;
    req_op[3] = PASSB; req_a[3] = 32'd0; req_b[3] = 32'h1234;
    for (int j = 0; j < 3; j++) begin
      tick(g, rdy);
      check("bp_no_grant", 64'(rdy), 64'(0));
      expect_now("bp_hold", 2, 32'hA5A5_5A5A, 1'b0);
    end
    rsp_ready = 1'b1;
    tick(g, rdy);
    check("bp_release_grant", 64'(rdy), 64'(4'b1000));
    req_valid = 4'b0011;
    tick(g, rdy);
    tick(g, rdy);
    req_valid = '0;
    tick(g, rdy);

    // Illegal op still consumes the slot; next legal op on the same port works.
    issue1(2, 8'h0B, 32'h1111_1111, 32'h2222_2222);
    expect_now("illegal", 2, 32'h0, 1'b1);
    issue1(2, OR, 32'hF0, 32'h0F);
    expect_now("after_illegal", 2, 32'hFF, 1'b0);

    // Wrap and sign behaviour.
    issue1(1, SUB, 32'd0, 32'd1);
    expect_now("sub_wrap", 1, 32'hFFFF_FFFF, 1'b0);
    issue1(3, SRA, 32'h8000_0000, 32'd4);
    expect_now("sra_sign", 3, 32'hF800_0000, 1'b0);
    issue1(0, SLTU, 32'd1, 32'hFFFF_FFFF);
    expect_now("sltu", 0, 32'd1, 1'b0);
    tick(g, rdy);

    // Randomized traffic; a requester only changes after its own handshake.
    pend = '0;
    g    = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] || g == i) begin
          pend[i] = ($urandom_range(0, 99) < 60);
          req_op[i] = ($urandom_range(0, 99) < 10) ? 8'($urandom_range(11, 255))
                                                   : 8'($urandom_range(0, 10));
          req_a[i]  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
          req_b[i]  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 99) < 70);
      tick(g, rdy);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick(g, rdy);
    tick(g, rdy);

    // Reset mid-operation: response discarded, requester 0 first afterwards.
    issue1(0, ADD, 32'd1, 32'd2);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_op[1] = ADD;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst_req_ready", 64'(req_ready), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b0011;
    req_op[0] = OR;  req_a[0] = 32'h3; req_b[0] = 32'hC;
    rsp_ready = 1'b1;
    tick(g, rdy);
    check("postrst_first", 64'(rdy), 64'(4'b0001));
    req_valid = 4'b0010;
    tick(g, rdy);
    check("postrst_second", 64'(rdy), 64'(4'b0010));
    req_valid = '0;
    tick(g, rdy);
    tick(g, rdy);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
